regfile_nrmw: RTL and testbench
===============================

REGFILE_NRMW -- requirements
Module: regfile_nrmw

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, SHALL set address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set word width and SHALL be a multiple of 8.
REQ-003 Parameter NR_READ, default 4, SHALL set the number of read ports (>=1).
REQ-004 Parameter NR_WRITE, default 2, SHALL set the number of write ports (>=1).
REQ-005 Parameter BYPASS, default 1: 1 = write-first forwarding, 0 = read-first.
REQ-006 Parameter INIT_CLEAR, default 1: 1 = zero all entries after reset, 0 = no clear.
REQ-007 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-008 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-009 ready  output  1  high when the array accepts reads/writes.
REQ-010 re  input  [NR_READ]  per-port read enable.
REQ-011 raddr  input  [NR_READ][ADDR_WIDTH]  read addresses.
REQ-012 rdata  output  [NR_READ][DATA_WIDTH]  registered read data.
REQ-013 we  input  [NR_WRITE]  per-port write enable.
REQ-014 waddr  input  [NR_WRITE][ADDR_WIDTH]  write addresses.
REQ-015 wdata  input  [NR_WRITE][DATA_WIDTH]  write data.
REQ-016 wbe  input  [NR_WRITE][DATA_WIDTH/8]  per-byte write enables; byte b covers bits 8b+7:8b.

Function
REQ-017 FSM states CLEAR and RUN; after reset SHALL enter CLEAR if INIT_CLEAR=1, else RUN.
REQ-018 In CLEAR, an ADDR_WIDTH-bit counter SHALL write zero to entry counter each cycle, 0 to DEPTH-1, one entry per cycle.
REQ-019 CLEAR -> RUN SHALL occur on the cycle after writing entry DEPTH-1; ready SHALL rise that same edge (clear takes exactly DEPTH cycles after reset release).
REQ-020 ready SHALL be 0 in CLEAR and 1 in RUN.
REQ-021 In CLEAR, we/re SHALL be ignored; array contents other than the clear write and rdata SHALL not change.
REQ-022 In RUN, for each write port w with we[w]=1, bytes of mem[waddr[w]] with wbe[w][b]=1 SHALL take wdata[w] bytes at the clock edge; wbe=0 bytes unchanged.
REQ-023 Write collision (same waddr, multiple enabled ports): per byte, the highest-index port with that byte enabled SHALL win.
REQ-024 Read latency SHALL be 1 cycle: re[r]=1 at edge k -> rdata[r] valid after edge k, held until next enabled read.
REQ-025 re[r]=0 SHALL hold rdata[r] unchanged.
REQ-026 BYPASS=1: rdata SHALL equal the post-write value of mem[raddr] (old bytes merged with all same-cycle enabled write bytes per REQ-022/023).
REQ-027 BYPASS=0: rdata SHALL equal the pre-write value of mem[raddr].
REQ-028 Multiple read ports on the same address SHALL return identical data.
REQ-029 Reads and writes SHALL be independent across ports; no stalls, no back-pressure in RUN.

Reset
REQ-030 On rst_n low, rdata SHALL clear to 0, ready to 0 (INIT_CLEAR=1) or 1 (INIT_CLEAR=0), counter to 0, FSM to CLEAR/RUN per REQ-017, asynchronously.
REQ-031 Array storage SHALL not be reset directly; zeroing is by the CLEAR sequence only.
REQ-032 Reset asserted mid-CLEAR SHALL restart clearing at entry 0 after release.
REQ-033 Reset asserted in RUN with INIT_CLEAR=0 SHALL leave array contents undefined-but-unmodified.

Verification
REQ-034 Defaults, release rst_n, hold re=all-1 raddr=5 -> ready rises exactly 64 cycles later; every read of any address after that returns 0.
REQ-035 RUN, port0 write addr 3 = 0x1122334455667788 wbe=0xFF, next cycle re port2 addr 3 -> rdata[2]=0x1122334455667788 one cycle later.
REQ-036 Entry 7 = 0, same cycle port0 writes 0xAA..AA wbe=0x0F and port1 writes 0xBB..BB wbe=0x3C, port0 reads 7 -> BYPASS=1: 0x00000000BBBBAAAA? per byte: bytes0-1=AA, bytes2-5=BB, bytes6-7=00 -> 0x0000BBBBBBBBAAAA; BYPASS=0: 0; following read 0x0000BBBBBBBBAAAA.
REQ-037 re[1] held 0 while addr 1 rewritten -> rdata[1] unchanged until re[1]=1.
REQ-038 Assert rst_n low at clear count 30, release -> ready rises 64 cycles after release; we pulses during CLEAR leave all entries 0.
REQ-039 INIT_CLEAR=0 -> ready=1 on reset release; write/read addr 63 round-trips after 1-cycle latency.

Source files
------------

// File: rtl/regfile_nrmw.sv
// Multi-ported register file with per-byte write enables, same-cycle write collision
// resolution, optional write-first forwarding and an optional post-reset zeroing sweep.
module regfile_nrmw #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int NR_READ    = 4,
    parameter int NR_WRITE   = 2,
    parameter int BYPASS     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    output logic                                     ready,
    input  logic [NR_READ-1:0]                       re,
    input  logic [NR_READ-1:0][ADDR_WIDTH-1:0]       raddr,
    output logic [NR_READ-1:0][DATA_WIDTH-1:0]       rdata,
    input  logic [NR_WRITE-1:0]                      we,
    input  logic [NR_WRITE-1:0][ADDR_WIDTH-1:0]      waddr,
    input  logic [NR_WRITE-1:0][DATA_WIDTH-1:0]      wdata,
    input  logic [NR_WRITE-1:0][DATA_WIDTH/8-1:0]    wbe
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_next;
    logic                    w_run;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    assign w_run = (r_state == S_RUN);
    assign ready = w_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                w_cnt_next = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    // Ports are applied in ascending order so the highest-index port wins each byte.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int w = 0; w < NR_WRITE; w++) begin
                for (int b = 0; b < NB; b++) begin
                    if (we[w] && wbe[w][b]) begin
                        r_mem[waddr[w]][8*b +: 8] <= wdata[w][8*b +: 8];
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NR_READ; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] w_rd_val;
            logic [DATA_WIDTH-1:0] r_rdata;

            // Forwarding merges every same-cycle enabled write byte onto the stored word.
            always_comb begin
                w_rd_val = r_mem[raddr[gi]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NR_WRITE; w++) begin
                        for (int b = 0; b < NB; b++) begin
                            if (we[w] && wbe[w][b] && (waddr[w] == raddr[gi])) begin
                                w_rd_val[8*b +: 8] = wdata[w][8*b +: 8];
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (w_run && re[gi]) begin
                    r_rdata <= w_rd_val;
                end
            end

            assign rdata[gi] = r_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_nrmw.sv
// Bench for regfile_nrmw: write-first, read-first and no-clear instances driven together,
// checked each cycle against an array model plus directed literal expectations.
module tb_regfile_nrmw;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]        re;
    logic [3:0][5:0]   raddr;
    logic [1:0]        we;
    logic [1:0][5:0]   waddr;
    logic [1:0][63:0]  wdata;
    logic [1:0][7:0]   wbe;

    logic [3:0]        c_re;
    logic [3:0][5:0]   c_raddr;
    logic [1:0]        c_we;
    logic [1:0][5:0]   c_waddr;
    logic [1:0][63:0]  c_wdata;
    logic [1:0][7:0]   c_wbe;

    logic              ready_a, ready_b, ready_c;
    logic [3:0][63:0]  rdata_a, rdata_b, rdata_c;

    regfile_nrmw #(.BYPASS(1), .INIT_CLEAR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ready(ready_a), .re(re), .raddr(raddr), .rdata(rdata_a),
        .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe));
    regfile_nrmw #(.BYPASS(0), .INIT_CLEAR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ready(ready_b), .re(re), .raddr(raddr), .rdata(rdata_b),
        .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe));
    regfile_nrmw #(.BYPASS(1), .INIT_CLEAR(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .ready(ready_c), .re(c_re), .raddr(c_raddr), .rdata(rdata_c),
        .we(c_we), .waddr(c_waddr), .wdata(c_wdata), .wbe(c_wbe));

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word array plus cycles-since-release counter for the clear sweep.
    logic [63:0]      mem_m [64];
    int               m_cycles = 0;
    logic             m_ready = 1'b0;
    logic [3:0][63:0] exp_bp = '0;
    logic [3:0][63:0] exp_b0 = '0;

    function automatic logic [63:0] post_write(input logic [5:0] a);
        logic [63:0] v;
        v = mem_m[a];
        for (int w = 0; w < 2; w++)
            for (int b = 0; b < 8; b++)
                if (we[w] && wbe[w][b] && waddr[w] == a) v[8*b +: 8] = wdata[w][8*b +: 8];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cycles = 0;
            m_ready  = 1'b0;
            exp_bp   = '0;
            exp_b0   = '0;
        end else if (!m_ready) begin
            mem_m[m_cycles] = '0;
            m_cycles++;
            if (m_cycles == 64) m_ready = 1'b1;
        end else begin
            for (int r = 0; r < 4; r++) begin
                if (re[r]) begin
                    exp_b0[r] = mem_m[raddr[r]];
                    exp_bp[r] = post_write(raddr[r]);
                end
            end
            for (int a = 0; a < 64; a++) mem_m[a] = post_write(6'(a));
        end
    end

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("ready_a", 256'(ready_a), 256'(m_ready));
            chk("ready_b", 256'(ready_b), 256'(m_ready));
            chk("rdata_bypass", 256'(rdata_a), 256'(exp_bp));
            chk("rdata_readfirst", 256'(rdata_b), 256'(exp_b0));
        end
    end

    task automatic idle();
        re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0; wbe = '0;
    endtask

    task automatic rand_inputs();
        re = 4'($urandom);
        we = 2'($urandom);
        for (int r = 0; r < 4; r++) raddr[r] = 6'($urandom_range(0, 15));
        for (int w = 0; w < 2; w++) begin
            waddr[w] = 6'($urandom_range(0, 15));
            wdata[w] = {$urandom, $urandom};
            wbe[w]   = 8'($urandom);
        end
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < 16; i++) begin
            re = '1;
            for (int r = 0; r < 4; r++) raddr[r] = 6'(4 * i + r);
            @(negedge clk);
            chk(name, 256'(rdata_a), 256'(0));
            chk(name, 256'(rdata_b), 256'(0));
        end
        re = '0;
    endtask

    task automatic wait_ready(output int n, input bit poke);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (poke && !ready_a) rand_inputs();
        end while (!ready_a && n < 200);
        idle();
    endtask

    logic [63:0] c_val;
    int n;

    initial begin
        idle();
        c_re = '0; c_raddr = '0; c_we = '0; c_waddr = '0; c_wdata = '0; c_wbe = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ready_a", 256'(ready_a), 256'(0));
        chk("reset_rdata_a", 256'(rdata_a), 256'(0));
        chk("reset_ready_b", 256'(ready_b), 256'(0));
        chk("reset_ready_noclear", 256'(ready_c), 256'(1));
        repeat (2) @(negedge clk);
        re = '1;
        for (int r = 0; r < 4; r++) raddr[r] = 6'd5;
        rst_n = 1'b1;
        chk_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_a && n < 200);
        chk("clear_cycles", 256'(n), 256'(64));
        idle();
        sweep_zero("sweep_after_init");

        we[0] = 1'b1; waddr[0] = 6'd3; wdata[0] = 64'h1122334455667788; wbe[0] = 8'hFF;
        @(negedge clk);
        idle();
        re = 4'b0100; raddr[2] = 6'd3;
        @(negedge clk);
        re = '0;
        chk("write_then_read", 256'(rdata_a[2]), 256'(64'h1122334455667788));
        chk("write_then_read_rf", 256'(rdata_b[2]), 256'(64'h1122334455667788));

        we = 2'b11; waddr[0] = 6'd7; waddr[1] = 6'd7;
        wdata[0] = 64'hAAAAAAAAAAAAAAAA; wbe[0] = 8'h0F;
        wdata[1] = 64'hBBBBBBBBBBBBBBBB; wbe[1] = 8'h3C;
        re = 4'b0001; raddr[0] = 6'd7;
        @(negedge clk);
        we = '0;
        chk("collide_bypass", 256'(rdata_a[0]), 256'(64'h0000BBBBBBBBAAAA));
        chk("collide_readfirst", 256'(rdata_b[0]), 256'(0));
        @(negedge clk);
        re = '0;
        chk("collide_followup", 256'(rdata_b[0]), 256'(64'h0000BBBBBBBBAAAA));

        re = 4'b0010; raddr[1] = 6'd1;
        @(negedge clk);
        re = '0;
        chk("hold_before", 256'(rdata_a[1]), 256'(0));
        we[0] = 1'b1; waddr[0] = 6'd1; wdata[0] = 64'hDEADBEEFCAFEF00D; wbe[0] = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("hold_no_re", 256'(rdata_a[1]), 256'(0));
        end
        we = '0; re = 4'b0010;
        @(negedge clk);
        re = '0;
        chk("hold_after_re", 256'(rdata_a[1]), 256'(64'hDEADBEEFCAFEF00D));

        repeat (1500) begin
            rand_inputs();
            @(negedge clk);
        end
        idle();

        rst_n = 1'b0;
        #1;
        chk("async_reset_ready", 256'(ready_a), 256'(0));
        chk("async_reset_rdata", 256'(rdata_a), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            rand_inputs();
        end
        rst_n = 1'b0;
        #1;
        chk("midclear_reset_ready", 256'(ready_a), 256'(0));
        chk("midclear_reset_rdata_rf", 256'(rdata_b), 256'(0));
        chk("midclear_noclear_ready", 256'(ready_c), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n, 1'b1);
        chk("reclear_cycles", 256'(n), 256'(64));
        sweep_zero("sweep_after_reclear");

        chk("noclear_ready", 256'(ready_c), 256'(1));
        c_val = {$urandom, $urandom};
        c_we = 2'b01; c_waddr[0] = 6'd63; c_wdata[0] = c_val; c_wbe[0] = 8'hFF;
        @(negedge clk);
        c_we = '0; c_re = 4'b1000; c_raddr[3] = 6'd63;
        @(negedge clk);
        c_re = '0;
        chk("noclear_roundtrip", 256'(rdata_c[3]), 256'(c_val));

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
